mem_ctrl: RTL and testbench

Memory-access controller between the MEM stage and a byte-wide synchronous RAM. It accepts one 32-bit request per instruction (address, write enable, 4-bit byte-lane select, store data) and serialises it into one RAM byte access per lane, stalling the pipeline until done. For loads it assembles the returned bytes into the 32-bit word the MEM stage consumes as its load data.

---
 rtl/mem_ctrl_if.sv | 31 +++
 rtl/mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: MEM-stage request/response signals plus the byte-wide RAM port of mem_ctrl.
// master = pipeline + RAM side (drives requests and RAM read data), slave = the controller.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  // MEM-stage request
  logic              ce_i;
  logic              we_i;
  logic [31:0]       addr_i;
  logic [3:0]        sel_i;
  logic [31:0]       data_i;
  logic              pipe_hold_i;
  // MEM-stage response
  logic [31:0]       data_o;
  logic              stall_req_o;
  // byte RAM port
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_we_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i, pipe_hold_i, ram_din_i,
    input  data_o, stall_req_o, ram_addr_o, ram_we_o, ram_dout_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i, pipe_hold_i, ram_din_i,
    output data_o, stall_req_o, ram_addr_o, ram_we_o, ram_dout_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises one 32-bit MEM-stage access into per-lane byte accesses on a
// synchronous byte RAM, stalling the pipeline until the access completes.
// Lane k = byte at word base + k = sel bit 3-k = data bits [31-8k -: 8].
// Optional feature: define MEM_CTRL_LANE_SKIP_EN to visit only enabled lanes;
// otherwise every nonzero request walks lanes 0..3 (disabled lanes read, never written).
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input logic        clk,
  input logic        rst,
  mem_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_lane;
  logic              r_we;
  logic [ADDR_W-3:0] r_word;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic              r_pend;
  logic [1:0]        r_pend_lane;
  logic [ADDR_W-1:0] r_addr_hold;

  logic [1:0]        w_first_lane;
  logic [1:0]        w_next_lane;
  logic              w_last_lane;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wbyte;
  logic              w_lane_en;
  logic [31:0]       w_mask;
  logic              w_unused_ok;

  // sel bit 3-k belongs to lane k, and ~k == 3-k for a 2-bit lane index
  assign w_addr    = {r_word, r_lane};
  assign w_lane_en = r_sel[~r_lane];
  assign w_wbyte   = r_wdata[{~r_lane, 3'b000} +: 8];
  assign w_mask    = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
  assign w_unused_ok = &{1'b0, bus.addr_i};

`ifdef MEM_CTRL_LANE_SKIP_EN
  logic [3:0] w_req_lanes;
  logic [3:0] w_cur_lanes;
  logic       w_found;
  assign w_req_lanes = {bus.sel_i[0], bus.sel_i[1], bus.sel_i[2], bus.sel_i[3]};
  assign w_cur_lanes = {r_sel[0], r_sel[1], r_sel[2], r_sel[3]};

  // lowest enabled lane of the incoming request; next enabled lane above the current one
  always_comb begin
    w_first_lane = '0;
    w_next_lane  = r_lane;
    w_last_lane  = 1'b1;
    w_found      = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!w_found && w_req_lanes[i[1:0]]) begin
        w_found      = 1'b1;
        w_first_lane = i[1:0];
      end
      if (w_last_lane && (i > 32'(r_lane)) && w_cur_lanes[i[1:0]]) begin
        w_last_lane = 1'b0;
        w_next_lane = i[1:0];
      end
    end
  end
`else
  // full walk: always start at lane 0 and step through lane 3
  always_comb begin
    w_first_lane = '0;
    w_next_lane  = r_lane + 2'd1;
    w_last_lane  = (r_lane == 2'd3);
  end
`endif

  // sequencing, request latch and load-byte capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lane      <= '0;
      r_we        <= 1'b0;
      r_word      <= '0;
      r_sel       <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_pend      <= 1'b0;
      r_pend_lane <= '0;
      r_addr_hold <= '0;
    end else begin
      // read data arrives one cycle after its address; the tag says which byte it fills
      r_pend <= 1'b0;
      if (r_pend) r_buf[{~r_pend_lane, 3'b000} +: 8] <= bus.ram_din_i;
      case (r_state)
        S_IDLE: begin
          if (bus.ce_i) begin
            r_we    <= bus.we_i;
            r_word  <= bus.addr_i[ADDR_W-1:2];
            r_sel   <= bus.sel_i;
            r_wdata <= bus.data_i;
            r_buf   <= '0;
            r_lane  <= w_first_lane;
            r_state <= (bus.sel_i == 4'd0) ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_addr_hold <= w_addr;
          r_pend      <= ~r_we;
          r_pend_lane <= r_lane;
          if (w_last_lane) r_state <= r_we ? S_DONE : S_FLUSH;
          else             r_lane  <= w_next_lane;
        end
        S_FLUSH: r_state <= S_DONE;
        S_DONE:  if (!bus.pipe_hold_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes and stall; both forced quiet while reset is asserted
  always_comb begin
    bus.stall_req_o = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_dout_o  = '0;
    bus.ram_addr_o  = r_addr_hold;
    if (!rst) begin
      case (r_state)
        S_IDLE:   bus.stall_req_o = bus.ce_i;
        S_ACCESS: begin
          bus.stall_req_o = 1'b1;
          bus.ram_we_o    = r_we & w_lane_en;
          bus.ram_dout_o  = w_wbyte;
          bus.ram_addr_o  = w_addr;
        end
        S_FLUSH:  bus.stall_req_o = 1'b1;
        default:  bus.stall_req_o = 1'b0;
      endcase
    end
  end

  // load word: buffer is cleared per request and only filled by loads, so stores read 0
  always_comb begin
    bus.data_o = r_buf & w_mask;
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector table, hand-written reset/hold sequences and randomized
// requests for mem_ctrl, checked against a byte-array model of the RAM contents.
// Honours MEM_CTRL_LANE_SKIP_EN for the expected latency and write schedule.
module tb_mem_ctrl;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;
  logic ram_clr;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(AW)) bus ();
  mem_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // synchronous byte RAM seen by the controller
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    end else if (bus.ram_we_o) begin
      ram[bus.ram_addr_o[9:0]] <= bus.ram_dout_o;
    end
    bus.ram_din_i <= ram[bus.ram_addr_o[9:0]];
  end

  // reference memory image
  logic [7:0] ref_mem [0:1023];

  typedef struct {
    int unsigned cyc;
    logic [31:0] addr;
    logic [7:0]  b;
  } wr_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    int unsigned hold;
    logic [31:0] exp_data;
    int unsigned lat_skip;
    int unsigned lat_full;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic lane_on(input logic [3:0] sel, input int unsigned k);
    logic [3:0] lanes;
    lanes = {sel[0], sel[1], sel[2], sel[3]};
    return lanes[k[1:0]];
  endfunction

  function automatic int unsigned model_lanes(input logic [3:0] sel);
`ifdef MEM_CTRL_LANE_SKIP_EN
    return $countones(sel);
`else
    return (sel != 4'd0) ? 4 : 0;
`endif
  endfunction

  // cycles from acceptance (T) to the first DONE cycle
  function automatic int unsigned model_lat(input logic we, input logic [3:0] sel);
    int unsigned n;
    n = model_lanes(sel);
    if (n == 0) return 1;
    return we ? n + 1 : n + 2;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [3:0] sel);
    logic [31:0] base;
    logic [31:0] w;
    base = {addr[31:2], 2'b00};
    w = '0;
    for (int unsigned k = 0; k < 4; k++)
      if (lane_on(sel, k)) w = w | ({24'd0, ref_mem[10'(base + k)]} << (8 * (3 - k)));
    return w;
  endfunction

  // one complete request starting in the next IDLE cycle; returns at the last DONE cycle
  task automatic run_req(input string name, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] data, input int unsigned hold,
                         input logic [31:0] exp_data, input int unsigned exp_lat);
    wr_t exp_q[$];
    wr_t got_q[$];
    int unsigned cyc;
    int unsigned lat;
    int unsigned c;
    int unsigned nbad;
    logic [31:0] base;
    logic [31:0] held_addr;
    base = {addr[31:2], 2'b00};
    c = 1;
    for (int unsigned k = 0; k < 4; k++) begin
`ifdef MEM_CTRL_LANE_SKIP_EN
      if (lane_on(sel, k)) begin
        if (we) exp_q.push_back('{c, base + k, 8'(data >> (8 * (3 - k))))});
        c++;
      end
`else
      if (lane_on(sel, k) && we) exp_q.push_back('{k + 1, base + k, 8'(data >> (8 * (3 - k)))});
`endif
      if (lane_on(sel, k) && we) ref_mem[10'(base + k)] = 8'(data >> (8 * (3 - k)));
    end

    @(negedge clk);
    bus.ce_i = 1'b1;
    bus.we_i = we;
    bus.addr_i = addr;
    bus.sel_i = sel;
    bus.data_i = data;
    bus.pipe_hold_i = 1'b0;
    #1 check({name, " stall@T"}, 32'(bus.stall_req_o), 32'd1);

    lat = 0;
    cyc = 0;
    while (lat == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.ce_i   = 1'b0;
        bus.we_i   = 1'($urandom);
        bus.addr_i = $urandom;
        bus.sel_i  = 4'($urandom);
        bus.data_i = $urandom;
      end
      if (bus.ram_we_o) got_q.push_back('{cyc, bus.ram_addr_o, bus.ram_dout_o});
      if (!bus.stall_req_o) lat = cyc;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " data_o"}, bus.data_o, exp_data);

    nbad = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr !== exp_q[i].addr || got_q[i].b !== exp_q[i].b)
        nbad++;
    check({name, " write-trace mismatches"}, nbad, 0);

    // while held in DONE a fresh request must be ignored and the RAM left alone
    held_addr = bus.ram_addr_o;
    if (hold > 0) begin
      bus.pipe_hold_i = 1'b1;
      for (int unsigned j = 0; j < hold; j++) begin
        bus.ce_i = 1'b1;
        bus.sel_i = 4'($urandom_range(1, 15));
        bus.we_i = 1'($urandom);
        bus.addr_i = $urandom;
        @(negedge clk);
        check({name, " hold data_o"}, bus.data_o, exp_data);
        check({name, " hold stall/we/addr-moved"},
              {29'd0, bus.stall_req_o, bus.ram_we_o, 1'(bus.ram_addr_o !== held_addr)}, 32'd0);
      end
      bus.ce_i = 1'b0;
      bus.pipe_hold_i = 1'b0;
    end
  endtask

  vec_t vecs[11];
  int unsigned lat;
  logic        rwe;
  logic [31:0] raddr;
  logic [3:0]  rsel;
  logic [31:0] rdata;
  int unsigned rhold;
  int unsigned nbad;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // directed vectors: we, addr, sel, data, hold, exp data_o, latency (skip on / skip off)
    vecs[0]  = '{1'b1, 32'h0000_0100, 4'b1111, 32'h1122_3344, 0, 32'h0000_0000, 5, 5};
    vecs[1]  = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 0, 32'h1122_3344, 6, 6};
    vecs[2]  = '{1'b0, 32'h0000_0102, 4'b0010, 32'h0000_0000, 0, 32'h0000_3300, 3, 6};
    vecs[3]  = '{1'b1, 32'h0000_0200, 4'b1000, 32'hAA00_0000, 3, 32'h0000_0000, 2, 5};
    vecs[4]  = '{1'b1, 32'h0000_0200, 4'b1000, 32'hBB00_0000, 0, 32'h0000_0000, 2, 5};
    vecs[5]  = '{1'b0, 32'h0000_0200, 4'b1111, 32'h0000_0000, 2, 32'hBB00_0000, 6, 6};
    vecs[6]  = '{1'b1, 32'h0000_0204, 4'b0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1, 1};
    vecs[7]  = '{1'b0, 32'h0000_0204, 4'b0000, 32'h0000_0000, 0, 32'h0000_0000, 1, 1};
    vecs[8]  = '{1'b1, 32'h0000_0103, 4'b0011, 32'hDEAD_5566, 0, 32'h0000_0000, 3, 5};
    vecs[9]  = '{1'b0, 32'h0000_0101, 4'b1111, 32'h0000_0000, 0, 32'h1122_5566, 6, 6};
    vecs[10] = '{1'b0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 0, 32'h1100_0000, 3, 6};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    // reset held two cycles with a live request on the bus
    rst = 1'b1;
    ram_clr = 1'b1;
    bus.ce_i = 1'b1;
    bus.we_i = 1'b1;
    bus.addr_i = 32'h0000_0040;
    bus.sel_i = 4'b1111;
    bus.data_i = 32'hFFFF_FFFF;
    bus.pipe_hold_i = 1'b0;
    #1 check("reset stall/we (async view)", {30'd0, bus.stall_req_o, bus.ram_we_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset stall/we", {30'd0, bus.stall_req_o, bus.ram_we_o}, 32'd0);
    check("reset data_o", bus.data_o, 32'd0);
    check("reset ram_addr_o", bus.ram_addr_o, 32'd0);
    check("reset ram_dout_o", {24'd0, bus.ram_dout_o}, 32'd0);
    rst = 1'b0;
    ram_clr = 1'b0;
    bus.ce_i = 1'b0;
    @(negedge clk);
    check("idle after reset stall", 32'(bus.stall_req_o), 32'd0);

    for (int i = 0; i < 11; i++) begin
`ifdef MEM_CTRL_LANE_SKIP_EN
      lat = vecs[i].lat_skip;
`else
      lat = vecs[i].lat_full;
`endif
      run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data,
              vecs[i].hold, vecs[i].exp_data, lat);
    end
    check("ram[0x100] after SW", {24'd0, ram[10'h100]}, 32'h11);
    check("ram[0x200] after two SB", {24'd0, ram[10'h200]}, 32'hBB);

    // store aborted by reset during the lane-2 cycle: lanes 0 and 1 land, 2 and 3 do not
    @(negedge clk);
    bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h0000_0300;
    bus.sel_i = 4'b1111; bus.data_i = 32'hA1B2_C3D4;
    @(negedge clk);
    bus.ce_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sw-abort lane2 addr", bus.ram_addr_o, 32'h0000_0302);
    rst = 1'b1;
    #1 check("sw-abort gated stall/we", {30'd0, bus.stall_req_o, bus.ram_we_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("sw-abort quiet stall/we", {30'd0, bus.stall_req_o, bus.ram_we_o}, 32'd0);
      @(negedge clk);
    end
    ref_mem[10'h300] = 8'hA1;
    ref_mem[10'h301] = 8'hB2;
    check("sw-abort ram[0x300..0x303]", {ram[10'h300], ram[10'h301], ram[10'h302], ram[10'h303]},
          32'hA1B2_0000);

    // load aborted in the lane-2 cycle: buffer cleared, no further RAM activity
    bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0000_0100; bus.sel_i = 4'b1111;
    @(negedge clk);
    bus.ce_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("lw-abort data_o", bus.data_o, 32'd0);
    for (int j = 0; j < 3; j++) begin
      check("lw-abort quiet stall/we", {30'd0, bus.stall_req_o, bus.ram_we_o}, 32'd0);
      @(negedge clk);
    end

    // randomized requests against the reference image
    for (int i = 0; i < 200; i++) begin
      rwe   = 1'($urandom_range(0, 1));
      raddr = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3))
            | (32'($urandom_range(0, 1)) << 20);
      rsel  = 4'($urandom_range(0, 15));
      rdata = $urandom;
      rhold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_req($sformatf("rnd%0d", i), rwe, raddr, rsel, rdata, rhold,
              rwe ? 32'd0 : model_load(raddr, rsel), model_lat(rwe, rsel));
    end

    nbad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) nbad++;
    check("final ram image mismatches", nbad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
